// File: rtl/fetch_queue.sv
// Prefetching instruction-fetch front end: sequential imem requests, credit-limited
// DEPTH-entry PC/instruction FIFO, redirect flush. Define FETCH_BYPASS_EN for empty-queue bypass.
module fetch_queue #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus_4,
  output logic [XLEN-1:0] out_instr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;

  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] resp_pc_reg;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [PW-1:0]   head_reg;
  logic [PW-1:0]   tail_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   outstanding_reg;
  logic [CW-1:0]   drop_cnt_reg;

  logic [SW-1:0]   credit_sum;
  logic [XLEN-1:0] redirect_target;
  logic            req_fire;
  logic            resp_live;
  logic            resp_drop;
  logic            bypass;
  logic            push;
  logic            pop;
  logic            fifo_nonempty;

  // Every in-flight or to-be-dropped response holds a slot, so a live response can always push.
  assign credit_sum      = SW'(count_reg) + SW'(outstanding_reg) + SW'(drop_cnt_reg);
  assign req_valid       = reset && !redirect_valid && (credit_sum < SW'(DEPTH));
  assign req_addr        = fetch_pc_reg;
  assign req_fire        = req_valid && req_ready;
  assign redirect_target = redirect_pc & ~XLEN'(3);

  assign fifo_nonempty = (count_reg != '0);
  assign resp_live     = reset && resp_valid && (drop_cnt_reg == '0) && !redirect_valid;
  assign resp_drop     = reset && resp_valid && (drop_cnt_reg != '0);
  assign pop           = fifo_nonempty && !redirect_valid && out_ready;
  assign push          = resp_live && !bypass;

`ifdef FETCH_BYPASS_EN
  assign bypass    = resp_live && !fifo_nonempty && out_ready;
  assign out_valid = !redirect_valid && (fifo_nonempty || bypass);
  assign out_pc    = fifo_nonempty ? pc_mem[head_reg]    : (bypass ? resp_pc_reg : '0);
  assign out_instr = fifo_nonempty ? instr_mem[head_reg] : (bypass ? resp_instr  : '0);
`else
  assign bypass    = 1'b0;
  assign out_valid = fifo_nonempty && !redirect_valid;
  // Gate to zero when empty so reset clears the visible outputs without resetting storage.
  assign out_pc    = fifo_nonempty ? pc_mem[head_reg]    : '0;
  assign out_instr = fifo_nonempty ? instr_mem[head_reg] : '0;
`endif

  assign out_pc_plus_4 = out_pc + XLEN'(4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else if (redirect_valid) begin
      fetch_pc_reg    <= redirect_target;
      resp_pc_reg     <= redirect_target;
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
      // Whatever arrives this cycle is already gone, live or stale.
      drop_cnt_reg    <= drop_cnt_reg + outstanding_reg - CW'(resp_valid);
    end else begin
      if (req_fire)  fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
      if (resp_live) resp_pc_reg  <= resp_pc_reg + XLEN'(4);
      if (resp_drop) drop_cnt_reg <= drop_cnt_reg - CW'(1);
      if (push)      tail_reg     <= tail_reg + PW'(1);
      if (pop)       head_reg     <= head_reg + PW'(1);
      outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(resp_live);
      count_reg       <= count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_reg]    <= resp_pc_reg;
      instr_mem[tail_reg] <= resp_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: latency-programmable imem responder plus per-scenario checks.
module tb_fetch_queue;

`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  logic [31:0] out_instr;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_instr(resp_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pc_plus_4(out_pc_plus_4), .out_instr(out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 1;

  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_out_valid;
  logic [31:0] s_out_pc;
  logic [31:0] s_out_pc4;
  logic [31:0] s_out_instr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // One cycle starting at a negedge: present imem response, sample, record accepted request.
  task automatic step();
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      resp_valid = 1'b1;
      resp_instr = instr_of(pend_q[0].addr);
      pend_q.delete(0);
    end else begin
      resp_valid = 1'b0;
      resp_instr = '0;
    end
    #1;
    s_req_valid = req_valid;
    s_req_addr  = req_addr;
    s_out_valid = out_valid;
    s_out_pc    = out_pc;
    s_out_pc4   = out_pc_plus_4;
    s_out_instr = out_instr;
    $display("cyc=%0d req=%0b addr=%h resp=%0b redir=%0b out=%0b pc=%h instr=%h",
             cyc, s_req_valid, s_req_addr, resp_valid, redirect_valid, s_out_valid, s_out_pc, s_out_instr);
    if (req_valid && req_ready) pend_q.push_back('{addr: req_addr, due: cyc + lat});
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    resp_valid = 1'b0;
    resp_instr = '0;
    pend_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic check_out(input string name, input logic exp_v, input logic [31:0] exp_pc);
    checks++;
    if (s_out_valid !== exp_v) begin
      errors++;
      $display("FAIL %s out_valid: got %0b expected %0b", name, s_out_valid, exp_v);
    end else if (exp_v && (s_out_pc !== exp_pc || s_out_pc4 !== exp_pc + 32'd4 ||
                           s_out_instr !== instr_of(exp_pc))) begin
      errors++;
      $display("FAIL %s out: got pc=%h pc4=%h instr=%h expected pc=%h pc4=%h instr=%h",
               name, s_out_pc, s_out_pc4, s_out_instr, exp_pc, exp_pc + 32'd4, instr_of(exp_pc));
    end
  endtask

  task automatic check_req(input string name, input logic exp_v, input logic [31:0] exp_addr);
    checks++;
    if (s_req_valid !== exp_v || (exp_v && s_req_addr !== exp_addr)) begin
      errors++;
      $display("FAIL %s req: got valid=%0b addr=%h expected valid=%0b addr=%h",
               name, s_req_valid, s_req_addr, exp_v, exp_addr);
    end
  endtask

  task automatic test_reset();
    req_ready = 1'b1; out_ready = 1'b1; redirect_pc = '0;
    reset = 1'b0; redirect_valid = 1'b0; resp_valid = 1'b0; resp_instr = '0;
    @(negedge clk);
    #1;
    checks++;
    if (req_valid !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got req=%0b out=%0b pc=%h instr=%h expected 0 0 0 0",
               req_valid, out_valid, out_pc, out_instr);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1; req_ready = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check_req("stream", 1'b1, 32'(4 * k));
      check_out("stream", k >= 2 - BYP, 32'(4 * (k - 2 + BYP)));
    end
  endtask

  task automatic test_full();
    logic [31:0] exp_pc [5];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC; exp_pc[4] = 32'h10;
    do_reset();
    lat = 1; req_ready = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check_req("fill", k < 4, 32'(4 * k));
    end
    check_out("full_hold", 1'b1, 32'h0);
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      if (j == 0) check_req("full_stall", 1'b0, 32'h0);
      if (j == 1) check_req("resume", 1'b1, 32'h10);
      check_out("drain", 1'b1, exp_pc[j]);
    end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    lat = 4; req_ready = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    check_req("redirect_cycle", 1'b0, 32'h0);
    check_out("redirect_cycle", 1'b0, 32'h0);
    redirect_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) check_req("redirect_target", 1'b1, 32'h100);
      check_out("after_redirect", k >= 5 - BYP, 32'h100 + 32'(4 * (k - 5 + BYP)));
    end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    lat = 2; req_ready = 1'b1; out_ready = 1'b1;
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_setup resp_valid: got %0b expected 1", resp_valid);
    end
    check_out("same_cycle_resp", 1'b0, 32'h0);
    redirect_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) check_req("same_cycle_target", 1'b1, 32'h200);
      check_out("same_cycle_after", k >= 3 - BYP, 32'h200 + 32'(4 * (k - 3 + BYP)));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 3; req_ready = 1'b1; out_ready = 1'b1;
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    step();
    redirect_pc = 32'h0000_0400;
    step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 0) check_req("b2b_target", 1'b1, 32'h400);
      check_out("b2b_after", k >= 4 - BYP, 32'h400 + 32'(4 * (k - 4 + BYP)));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    do_reset();
    lat = 1; req_ready = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_req("wrap", 1'b1, 32'hFFFF_FFF8 + 32'(4 * k));
      exp_pc = 32'hFFFF_FFF8 + 32'(4 * (k - 2 + BYP));
      check_out("wrap_out", k >= 2 - BYP, exp_pc);
      if (k == 3 - BYP) begin
        checks++;
        if (s_out_pc !== 32'hFFFF_FFFC || s_out_pc4 !== 32'h0) begin
          errors++;
          $display("FAIL wrap_pc4: got pc=%h pc4=%h expected pc=fffffffc pc4=00000000", s_out_pc, s_out_pc4);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    lat = 3; req_ready = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check_out("pre_reset", 1'b1, 32'h0);
    reset = 1'b0;
    #1;
    checks++;
    if (req_valid !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++;
      $display("FAIL midstream_reset: got req=%0b out=%0b pc=%h instr=%h expected 0 0 0 0",
               req_valid, out_valid, out_pc, out_instr);
    end
    pend_q.delete();
    out_ready = 1'b1;
    resp_valid = 1'b1; resp_instr = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (out_valid !== 1'b0 || req_valid !== 1'b0) begin
      errors++;
      $display("FAIL resp_in_reset: got out=%0b req=%0b expected 0 0", out_valid, req_valid);
    end
    @(negedge clk);
    resp_valid = 1'b0; resp_instr = '0;
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    lat = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) check_req("post_reset", 1'b1, 32'h0);
      check_out("post_reset_out", k >= 2 - BYP, 32'(4 * (k - 2 + BYP)));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_drop();
    test_redirect_same_cycle();
    test_back_to_back();
    test_wrap();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
